// File: rtl/div_pkg.sv
// div_iter shared types: FSM state encoding and sizing helper.
// Imported by the divider top and its interface.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Bits needed to count 0..n-1 (n >= 2).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// div_iter request/response bundle.
// master = issuing stage, slave = divider.
interface div_iter_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, q, r, dz
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, q, r, dz
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left,
// subtract divisor if it fits, shift in the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  assign w_ge   = (w_sh >= {2'b00, i_dsr});
  assign w_diff = w_sh[WIDTH:0] - {1'b0, i_dsr};
  assign o_rem  = w_ge ? w_diff : w_sh[WIDTH:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider, one quotient bit per
// clock, start/busy/done handshake for the execute stage.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset,
  div_iter_if.slave bus
);

  localparam int CW = clog2(WIDTH);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz_pend;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_last;

  // Magnitudes; |MIN| wraps to 2^(WIDTH-1) as unsigned.
  assign w_a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_b_mag = w_b_neg ? -bus.divisor : bus.divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dsr (r_dsr),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  // Sign fix-up; with a zero divisor the remainder path
  // already rebuilds the dividend, only q is forced.
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  assign w_r_fix = r_neg_r ? -r_rem[WIDTH-1:0]
                           : r_rem[WIDTH-1:0];
  assign w_q_fix = r_dz_pend ? '1
                 : (r_neg_q ? -r_quo : r_quo);

  // Sequencer, datapath and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dsr     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dz_pend <= 1'b0;
      r_done    <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_quo     <= w_a_mag;
            r_dsr     <= w_b_mag;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_dz_pend <= (bus.divisor == '0);
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_q     <= w_q_fix;
          r_r     <= w_r_fix;
          r_dz    <= r_dz_pend;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.dz   = r_dz;

endmodule

// File: tb/tb_div_iter.sv
// Directed vector bench for div_iter (WIDTH=32).
// Table of divides plus handshake/reset sequences.
module tb_div_iter;

  localparam int W = 32;

  logic clock;
  logic reset;
  int   errs;
  int   checks;

  div_iter_if #(.WIDTH(W)) bus ();

  div_iter #(
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic s);
    @(negedge clock);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts posedges until done is seen #1 after an edge.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock);
      #1;
      n++;
      if (bus.done) return;
    end
    n = -1;
  endtask

  int n;
  int n2;
  int dcnt;

  initial begin
    errs   = 0;
    checks = 0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    reset = 1'b1;

    vecs[0]  = '{32'd100, 32'd7, 1'b0,
                 32'd14, 32'd2, 1'b0};
    vecs[1]  = '{32'hFFFFFF9C, 32'd7, 1'b1,
                 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{32'd100, 32'hFFFFFFF9, 1'b1,
                 32'hFFFFFFF2, 32'd2, 1'b0};
    vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1,
                 32'd14, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1,
                 32'h80000000, 32'd0, 1'b0};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0,
                 32'd0, 32'h80000000, 1'b0};
    vecs[6]  = '{32'h12345678, 32'd0, 1'b0,
                 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[7]  = '{32'h12345678, 32'd0, 1'b1,
                 32'hFFFFFFFF, 32'h12345678, 1'b1};
    vecs[8]  = '{32'd1000, 32'd10, 1'b0,
                 32'd100, 32'd0, 1'b0};
    vecs[9]  = '{32'hFFFFFFF8, 32'd0, 1'b1,
                 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1};
    vecs[10] = '{32'hFFFFFFFF, 32'd1, 1'b0,
                 32'hFFFFFFFF, 32'd0, 1'b0};
    vecs[11] = '{32'd7, 32'd100, 1'b1,
                 32'd0, 32'd7, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_q", 64'(bus.q), 64'd0);
    chk("rst_r", 64'(bus.r), 64'd0);
    chk("rst_dz", 64'(bus.dz), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s);
      chk($sformatf("v%0d_busy", i), 64'(bus.busy), 64'd1);
      wait_done(n);
      chk($sformatf("v%0d_lat", i), 64'(n), 64'd33);
      chk($sformatf("v%0d_q", i), 64'(bus.q), 64'(vecs[i].eq));
      chk($sformatf("v%0d_r", i), 64'(bus.r), 64'(vecs[i].er));
      chk($sformatf("v%0d_dz", i), 64'(bus.dz), 64'(vecs[i].edz));
      chk($sformatf("v%0d_bsy0", i), 64'(bus.busy), 64'd0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_pulse", i), 64'(bus.done), 64'd0);
    end

    // start while busy is ignored
    start_op(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("ign_lat", 64'(n), 64'd27);
    chk("ign_q", 64'(bus.q), 64'd14);
    chk("ign_r", 64'(bus.r), 64'd2);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("ign_nosecond", 64'(dcnt), 64'd0);

    // start raised in the done cycle
    start_op(32'd100, 32'd7, 1'b0);
    wait_done(n);
    chk("b2b_lat1", 64'(n), 64'd33);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd1000;
    bus.divisor   = 32'd10;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_hold_q", 64'(bus.q), 64'd14);
    wait_done(n);
    chk("b2b_lat2", 64'(n), 64'd33);
    chk("b2b_q", 64'(bus.q), 64'd100);
    chk("b2b_r", 64'(bus.r), 64'd0);

    // start held high: one result per WIDTH+2 cycles
    @(negedge clock);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd20;
    bus.divisor   = 32'd3;
    @(posedge clock);
    #1;
    wait_done(n);
    chk("hold_lat1", 64'(n), 64'd33);
    wait_done(n2);
    bus.start = 1'b0;
    chk("hold_lat2", 64'(n2), 64'd34);
    chk("hold_q", 64'(bus.q), 64'd6);
    chk("hold_r", 64'(bus.r), 64'd2);
    repeat (2) @(posedge clock);
    #1;
    chk("hold_idle", 64'(bus.busy), 64'd0);

    // reset in the middle of RUN
    start_op(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mr_busy", 64'(bus.busy), 64'd0);
    chk("mr_q", 64'(bus.q), 64'd0);
    chk("mr_r", 64'(bus.r), 64'd0);
    chk("mr_done", 64'(bus.done), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) dcnt++;
    end
    chk("mr_nodone", 64'(dcnt), 64'd0);
    start_op(32'd1000, 32'd10, 1'b0);
    wait_done(n);
    chk("mr_lat", 64'(n), 64'd33);
    chk("mr_q2", 64'(bus.q), 64'd100);
    chk("mr_r2", 64'(bus.r), 64'd0);
    chk("mr_dz2", 64'(bus.dz), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
